// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: state codes, opcodes
// and the datapath select values also used by the ALU decoder.
package mainfsm_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECUTER = 4'd6;
  localparam logic [3:0] ST_EXECUTEI = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_JAL      = 4'd9;
  localparam logic [3:0] ST_BEQ      = 4'd10;

  typedef enum logic [3:0] {
    FETCH    = ST_FETCH,
    DECODE   = ST_DECODE,
    MEMADR   = ST_MEMADR,
    MEMREAD  = ST_MEMREAD,
    MEMWB    = ST_MEMWB,
    MEMWRITE = ST_MEMWRITE,
    EXECUTER = ST_EXECUTER,
    EXECUTEI = ST_EXECUTEI,
    ALUWB    = ST_ALUWB,
    JAL      = ST_JAL,
    BEQ      = ST_BEQ
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mainfsm_instrdec.sv
// Immediate-format select decoded straight from the opcode; valid in every
// state so the immediate generator never waits on the controller.
module instrdec
  import mainfsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] immsrc
);

  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_LW, OP_IALU: immsrc = IMM_I;
      OP_SW:          immsrc = IMM_S;
      OP_BEQ:         immsrc = IMM_B;
      OP_JAL:         immsrc = IMM_J;
      default:        immsrc = 2'b00;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and enables, counts retired instructions.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       aluop,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       resultsrc,
  output logic [1:0]       immsrc,
  output logic             adrsrc,
  output logic             irwrite,
  output logic             regwrite,
  output logic             memwrite,
  output logic             pcwrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  state_t state, next;
  logic   pcupdate, branch, retire;

  instrdec u_instrdec (
    .op     (op),
    .immsrc (immsrc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= next;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    next       = state;
    aluop      = ALUOP_ADD;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    resultsrc  = RES_ALUOUT;
    adrsrc     = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;

    case (state)
      FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        if (mem_ready) begin
          irwrite  = 1'b1;
          pcupdate = 1'b1;
          next     = DECODE;
        end
      end
      DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYP:      next = EXECUTER;
          OP_IALU:      next = EXECUTEI;
          OP_JAL:       next = JAL;
          OP_BEQ:       next = BEQ;
          default: begin
            illegal_op = 1'b1;
            next       = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        if (op == OP_LW)      next = MEMREAD;
        else if (op == OP_SW) next = MEMWRITE;
        else                  next = FETCH;
      end
      MEMREAD: begin
        adrsrc = 1'b1;
        if (mem_ready) next = MEMWB;
      end
      MEMWB: begin
        resultsrc = RES_RDATA;
        regwrite  = 1'b1;
        retire    = 1'b1;
        next      = FETCH;
      end
      MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          next   = FETCH;
        end
      end
      EXECUTER: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
        next    = ALUWB;
      end
      EXECUTEI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        next    = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        next     = FETCH;
      end
      JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
        next     = ALUWB;
      end
      BEQ: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        retire  = 1'b1;
        next    = FETCH;
      end
      default: next = FETCH;
    endcase

    // Reset aborts whatever is in flight: FETCH selects, every enable low.
    if (!rst_n) begin
      next       = FETCH;
      aluop      = ALUOP_ADD;
      alusrca    = SRCA_PC;
      alusrcb    = SRCB_FOUR;
      resultsrc  = RES_ALURESULT;
      adrsrc     = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      pcupdate   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
      retire     = 1'b0;
    end
  end

  assign pcwrite = pcupdate | (branch & zero);

endmodule

// File: tb/tb_mainfsm.sv
// Directed-vector bench for mainfsm: stimulus pushes the hand-computed output
// vector for each cycle, a monitor pops and compares on the falling edge.
module tb_mainfsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = 7'b0000000;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic [1:0]  aluop, alusrca, alusrcb, resultsrc, immsrc;
  logic        adrsrc, irwrite, regwrite, memwrite, pcwrite, illegal_op;
  logic [31:0] instret;

  typedef struct {
    string       name;
    logic [15:0] outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t exq[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  mainfsm #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .aluop      (aluop),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .immsrc     (immsrc),
    .adrsrc     (adrsrc),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .pcwrite    (pcwrite),
    .illegal_op (illegal_op),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  // Packs {aluop,srca,srcb,res,imm,adr,ir,rw,mw,pcw,ill}
  function automatic logic [15:0] e(input logic [1:0] ao, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] rs,
                                    input logic [1:0] im, input logic ad,
                                    input logic ir, input logic rw, input logic mw,
                                    input logic pw, input logic il);
    return {ao, sa, sb, rs, im, ad, ir, rw, mw, pw, il};
  endfunction

  task automatic step(input string nm, input logic rn, input logic [6:0] o,
                      input logic z, input logic mr, input logic [15:0] ex,
                      input logic [31:0] ic);
    exp_t t;
    @(posedge clk);
    #1;
    rst_n = rn; op = o; zero = z; mem_ready = mr;
    t.name = nm; t.outs = ex; t.cnt = ic;
    exq.push_back(t);
  endtask

  always @(negedge clk) begin
    if (exq.size() > 0) begin
      exp_t t;
      logic [15:0] act;
      t = exq.pop_front();
      act = {aluop, alusrca, alusrcb, resultsrc, immsrc, adrsrc, irwrite,
             regwrite, memwrite, pcwrite, illegal_op};
      checks++;
      if (act !== t.outs || instret !== t.cnt) begin
        errors++;
        $display("FAIL %s: outs=%04h instret=%0d, expected outs=%04h instret=%0d",
                 t.name, act, instret, t.outs, t.cnt);
      end
    end
  end

  initial begin
    // Reset, then release into FETCH with memory ready
    step("rst1", 0, RT, 0, 1, e(0,0,2,2,0,0,0,0,0,0,0), 0);
    step("rst2", 0, RT, 0, 1, e(0,0,2,2,0,0,0,0,0,0,0), 0);
    // R-type
    step("r_fetch", 1, RT, 0, 1, e(0,0,2,2,0,0,1,0,0,1,0), 0);
    step("r_dec",   1, RT, 0, 1, e(0,1,1,0,0,0,0,0,0,0,0), 0);
    step("r_exe",   1, RT, 1, 1, e(2,2,0,0,0,0,0,0,0,0,0), 0);
    step("r_wb",    1, RT, 0, 1, e(0,0,0,0,0,0,0,1,0,0,0), 0);
    // lw with two stall cycles in MEMREAD
    step("lw_fetch", 1, LW, 0, 1, e(0,0,2,2,0,0,1,0,0,1,0), 1);
    step("lw_dec",   1, LW, 0, 1, e(0,1,1,0,0,0,0,0,0,0,0), 1);
    step("lw_adr",   1, LW, 0, 1, e(0,2,1,0,0,0,0,0,0,0,0), 1);
    step("lw_rd0",   1, LW, 0, 0, e(0,0,0,0,0,1,0,0,0,0,0), 1);
    step("lw_rd1",   1, LW, 0, 0, e(0,0,0,0,0,1,0,0,0,0,0), 1);
    step("lw_rd2",   1, LW, 0, 1, e(0,0,0,0,0,1,0,0,0,0,0), 1);
    step("lw_wb",    1, LW, 0, 1, e(0,0,0,1,0,0,0,1,0,0,0), 1);
    // beq taken
    step("bt_fetch", 1, BQ, 1, 1, e(0,0,2,2,2,0,1,0,0,1,0), 2);
    step("bt_dec",   1, BQ, 1, 1, e(0,1,1,0,2,0,0,0,0,0,0), 2);
    step("bt_beq",   1, BQ, 1, 1, e(1,2,0,0,2,0,0,0,0,1,0), 2);
    // fetch stall with zero high, then beq not taken
    step("bn_stall", 1, BQ, 1, 0, e(0,0,2,2,2,0,0,0,0,0,0), 3);
    step("bn_fetch", 1, BQ, 0, 1, e(0,0,2,2,2,0,1,0,0,1,0), 3);
    step("bn_dec",   1, BQ, 0, 1, e(0,1,1,0,2,0,0,0,0,0,0), 3);
    step("bn_beq",   1, BQ, 0, 1, e(1,2,0,0,2,0,0,0,0,0,0), 3);
    // illegal opcode
    step("il_fetch", 1, BAD, 0, 1, e(0,0,2,2,0,0,1,0,0,1,0), 4);
    step("il_dec",   1, BAD, 0, 1, e(0,1,1,0,0,0,0,0,0,0,1), 4);
    // jal
    step("j_fetch", 1, JL, 0, 1, e(0,0,2,2,3,0,1,0,0,1,0), 4);
    step("j_dec",   1, JL, 0, 1, e(0,1,1,0,3,0,0,0,0,0,0), 4);
    step("j_jal",   1, JL, 0, 1, e(0,1,2,0,3,0,0,0,0,1,0), 4);
    step("j_wb",    1, JL, 0, 1, e(0,0,0,0,3,0,0,1,0,0,0), 4);
    // I-ALU
    step("i_fetch", 1, IA, 0, 1, e(0,0,2,2,0,0,1,0,0,1,0), 5);
    step("i_dec",   1, IA, 0, 1, e(0,1,1,0,0,0,0,0,0,0,0), 5);
    step("i_exe",   1, IA, 0, 1, e(2,2,1,0,0,0,0,0,0,0,0), 5);
    step("i_wb",    1, IA, 0, 1, e(0,0,0,0,0,0,0,1,0,0,0), 5);
    // sw, memory ready immediately
    step("s_fetch", 1, SW, 0, 1, e(0,0,2,2,1,0,1,0,0,1,0), 6);
    step("s_dec",   1, SW, 0, 1, e(0,1,1,0,1,0,0,0,0,0,0), 6);
    step("s_adr",   1, SW, 0, 1, e(0,2,1,0,1,0,0,0,0,0,0), 6);
    step("s_wr",    1, SW, 0, 1, e(0,0,0,0,1,1,0,0,1,0,0), 6);
    // sw stalled three cycles, then aborted by reset
    step("sa_fetch", 1, SW, 0, 1, e(0,0,2,2,1,0,1,0,0,1,0), 7);
    step("sa_dec",   1, SW, 0, 1, e(0,1,1,0,1,0,0,0,0,0,0), 7);
    step("sa_adr",   1, SW, 0, 1, e(0,2,1,0,1,0,0,0,0,0,0), 7);
    step("sa_wr0",   1, SW, 0, 0, e(0,0,0,0,1,1,0,0,1,0,0), 7);
    step("sa_wr1",   1, SW, 0, 0, e(0,0,0,0,1,1,0,0,1,0,0), 7);
    step("sa_wr2",   1, SW, 0, 0, e(0,0,0,0,1,1,0,0,1,0,0), 7);
    step("sa_rst",   0, SW, 0, 1, e(0,0,2,2,1,0,0,0,0,0,0), 7);
    step("sa_after", 1, SW, 0, 0, e(0,0,2,2,1,0,0,0,0,0,0), 0);
    step("sa_hold",  1, SW, 0, 0, e(0,0,2,2,1,0,0,0,0,0,0), 0);

    for (int i = 0; i < 10 && exq.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
